// File: rtl/cascade_stage.sv
// One stage of a cascadable modulus up/down counter: steps on the upstream
// ripple (level or rising edge), wraps over 0..limit and reports the wrap downstream.
module cascade_stage #(
    parameter int WIDTH     = 6,
    parameter int EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             ctrl,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] count,
    output logic             ripple_out,
    output logic             wrap_sticky
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             sticky_q, sticky_d;
    logic             carry_q;
    logic             step_s;
    logic             at_term_s;
    logic             wrap_s;

    // Step qualification and terminal-count detection for the current direction
    always_comb begin
        step_s    = carry_in;
        at_term_s = 1'b0;
        if (EDGE_MODE != 0) begin
            step_s = carry_in & ~carry_q;
        end else begin
            step_s = carry_in;
        end
        // Up counting treats anything at or above a (possibly lowered) limit as terminal
        if (ctrl) begin
            at_term_s = (count_q == ZERO);
        end else begin
            at_term_s = (count_q >= limit);
        end
        wrap_s     = step_s & ~load & at_term_s;
        ripple_out = wrap_s;
    end

    // Next count: load beats step beats hold
    always_comb begin
        count_d = count_q;
        if (load) begin
            if (load_val > limit) begin
                count_d = limit;
            end else begin
                count_d = load_val;
            end
        end else if (step_s) begin
            if (!ctrl) begin
                if (at_term_s) begin
                    count_d = ZERO;
                end else begin
                    count_d = count_q + ONE;
                end
            end else if (count_q > limit) begin
                count_d = limit;
            end else if (count_q == ZERO) begin
                count_d = limit;
            end else begin
                count_d = count_q - ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Sticky wrap flag: a wrap on the same edge overrides the clear
    always_comb begin
        sticky_d = sticky_q;
        if (wrap_s) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q  <= ZERO;
            sticky_q <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            sticky_q <= sticky_d;
            carry_q  <= carry_in;
        end
    end

    assign count       = count_q;
    assign wrap_sticky = sticky_q;

endmodule

// File: tb/tb_cascade_stage.sv
// Bench for cascade_stage: level- and edge-mode instances share stimulus and are
// compared every cycle against a rule-level reference model.
module tb_cascade_stage;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       ctrl = 1'b0;
    logic       carry_in = 1'b0;
    logic [5:0] limit = 6'd0;
    logic       load = 1'b0;
    logic [5:0] load_val = 6'd0;
    logic       clr_sticky = 1'b0;
    logic [5:0] cnt0, cnt1;
    logic       rip0, rip1, stk0, stk1;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt  [2];
    bit m_stk  [2];
    bit m_prev [2];

    always #5 clk = ~clk;

    cascade_stage #(.WIDTH(6), .EDGE_MODE(0)) dut0 (
        .clk(clk), .clear_n(clear_n), .ctrl(ctrl), .carry_in(carry_in),
        .limit(limit), .load(load), .load_val(load_val), .clr_sticky(clr_sticky),
        .count(cnt0), .ripple_out(rip0), .wrap_sticky(stk0)
    );

    cascade_stage #(.WIDTH(6), .EDGE_MODE(1)) dut1 (
        .clk(clk), .clear_n(clear_n), .ctrl(ctrl), .carry_in(carry_in),
        .limit(limit), .load(load), .load_val(load_val), .clr_sticky(clr_sticky),
        .count(cnt1), .ripple_out(rip1), .wrap_sticky(stk1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_stk[k]  = 1'b0;
            m_prev[k] = 1'b0;
        end
    endtask

    // Called at posedge+1: checks ripple mid-cycle, then state after the next edge
    task automatic tick();
        int nxt_cnt [2];
        bit nxt_stk [2];
        bit st, w, exp_rip;
        int lim, lv;
        @(negedge clk);
        lim = int'(limit);
        lv  = int'(load_val);
        for (int k = 0; k < 2; k++) begin
            st = (k == 1) ? (carry_in && !m_prev[k]) : carry_in;
            exp_rip = st && !load && (ctrl ? (m_cnt[k] == 0) : (m_cnt[k] >= lim));
            chk((k == 0) ? "ripple0" : "ripple1", (k == 0) ? 32'(rip0) : 32'(rip1), 32'(exp_rip));
            w = 1'b0;
            nxt_cnt[k] = m_cnt[k];
            if (load) begin
                nxt_cnt[k] = (lv > lim) ? lim : lv;
            end else if (st && !ctrl) begin
                if (m_cnt[k] >= lim) begin
                    nxt_cnt[k] = 0;
                    w = 1'b1;
                end else begin
                    nxt_cnt[k] = m_cnt[k] + 1;
                end
            end else if (st && ctrl) begin
                if (m_cnt[k] > lim) begin
                    nxt_cnt[k] = lim;
                end else if (m_cnt[k] == 0) begin
                    nxt_cnt[k] = lim;
                    w = 1'b1;
                end else begin
                    nxt_cnt[k] = m_cnt[k] - 1;
                end
            end
            nxt_stk[k] = w ? 1'b1 : (clr_sticky ? 1'b0 : m_stk[k]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = nxt_cnt[k];
            m_stk[k]  = nxt_stk[k];
            m_prev[k] = carry_in;
        end
        chk("count0", 32'(cnt0), 32'(m_cnt[0]));
        chk("count1", 32'(cnt1), 32'(m_cnt[1]));
        chk("sticky0", 32'(stk0), 32'(m_stk[0]));
        chk("sticky1", 32'(stk1), 32'(m_stk[1]));
    endtask

    initial begin
        clear_n = 1'b0;
        model_reset();
        #1;
        chk("rst_count0", 32'(cnt0), 32'd0);
        chk("rst_sticky1", 32'(stk1), 32'd0);
        @(posedge clk);
        #3;
        clear_n = 1'b1;
        limit = 6'd20;
        tick();

        // Up-count wrap over 0..20
        ctrl = 1'b0; carry_in = 1'b1;
        repeat (21) tick();
        chk("up_wrap_count", 32'(cnt0), 32'd0);
        chk("up_wrap_sticky", 32'(stk0), 32'd1);
        chk("edge_single_step", 32'(cnt1), 32'd1);

        // Down-count wrap from 0
        carry_in = 1'b0; load = 1'b1; load_val = 6'd0;
        tick();
        load = 1'b0; ctrl = 1'b1; carry_in = 1'b1;
        tick();
        chk("down_wrap_count", 32'(cnt0), 32'd20);
        carry_in = 1'b0;
        tick();
        carry_in = 1'b1;
        tick();
        chk("down_next0", 32'(cnt0), 32'd19);
        chk("down_next1", 32'(cnt1), 32'd19);

        // Edge mode: level held five cycles
        carry_in = 1'b0; load = 1'b1; load_val = 6'd0;
        tick();
        load = 1'b0; ctrl = 1'b0; carry_in = 1'b1;
        repeat (5) tick();
        chk("edge_hold_count1", 32'(cnt1), 32'd1);
        chk("level_hold_count0", 32'(cnt0), 32'd5);

        // Load beats step and clamps to limit
        carry_in = 1'b0; clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0; load = 1'b1; load_val = 6'd30; carry_in = 1'b1;
        tick();
        chk("load_clamp0", 32'(cnt0), 32'd20);
        chk("load_no_wrap0", 32'(stk0), 32'd0);
        load = 1'b0; carry_in = 1'b0;

        // Lowered limit, up and down
        limit = 6'd63; load = 1'b1; load_val = 6'd15;
        tick();
        load = 1'b0; limit = 6'd10; ctrl = 1'b0; carry_in = 1'b1;
        tick();
        chk("lowered_up0", 32'(cnt0), 32'd0);
        chk("lowered_up_sticky0", 32'(stk0), 32'd1);
        carry_in = 1'b0; limit = 6'd63; load = 1'b1; load_val = 6'd15;
        tick();
        load = 1'b0; limit = 6'd10; ctrl = 1'b1; carry_in = 1'b1;
        tick();
        chk("lowered_down0", 32'(cnt0), 32'd10);
        chk("lowered_down1", 32'(cnt1), 32'd10);

        // limit=0: every step is a wrap
        carry_in = 1'b0;
        tick();
        limit = 6'd0; ctrl = 1'b0; carry_in = 1'b1;
        repeat (3) tick();
        ctrl = 1'b1;
        tick();
        chk("limit0_count0", 32'(cnt0), 32'd0);

        // Asynchronous reset mid-cycle abandons a pending load
        carry_in = 1'b0; limit = 6'd20; load = 1'b1; load_val = 6'd7;
        tick();
        load = 1'b0;
        #1;
        clear_n = 1'b0;
        #1;
        chk("async_count0", 32'(cnt0), 32'd0);
        chk("async_sticky0", 32'(stk0), 32'd0);
        chk("async_count1", 32'(cnt1), 32'd0);
        model_reset();
        load = 1'b1; load_val = 6'd5; carry_in = 1'b1; ctrl = 1'b0;
        #1;
        load = 1'b0;
        clear_n = 1'b1;
        tick();
        chk("release_edge1", 32'(cnt1), 32'd1);

        // Clear coincident with a wrap keeps the flag
        carry_in = 1'b0; limit = 6'd3; load = 1'b1; load_val = 6'd3;
        tick();
        load = 1'b0; ctrl = 1'b0; carry_in = 1'b1; clr_sticky = 1'b1;
        tick();
        chk("clr_vs_wrap0", 32'(stk0), 32'd1);
        chk("clr_vs_wrap1", 32'(stk1), 32'd1);
        clr_sticky = 1'b0; carry_in = 1'b0;

        // Randomized traffic
        limit = 6'd12;
        repeat (400) begin
            ctrl       = 1'($urandom_range(0, 1));
            carry_in   = ($urandom_range(0, 3) != 0);
            load       = ($urandom_range(0, 15) == 0);
            load_val   = 6'($urandom);
            clr_sticky = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) limit = 6'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cascade_stage.md
CASCADE_STAGE -- requirements
Module: cascade_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the count width.
REQ-002 The block SHALL have parameter EDGE_MODE, default 0; 0 = step every cycle carry_in is high, 1 = step only on a carry_in 0->1 transition.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port clear_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port ctrl, input, 1 bit: direction; 0 = up, 1 = down, same convention as the upstream counter stage.
REQ-006 The block SHALL have port carry_in, input, 1 bit: the terminal-count (ripple_out) of the upstream stage, synchronous to clk.
REQ-007 The block SHALL have port limit, input, WIDTH bits: the modulus maximum; the stage counts over 0..limit.
REQ-008 The block SHALL have port load, input, 1 bit: a synchronous load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: the value loaded when load=1.
REQ-010 The block SHALL have port clr_sticky, input, 1 bit: a synchronous clear of wrap_sticky.
REQ-011 The block SHALL have port count, output, WIDTH bits: the registered stage value.
REQ-012 The block SHALL have port ripple_out, output, 1 bit: the combinational cascade carry to the next stage.
REQ-013 The block SHALL have port wrap_sticky, output, 1 bit: the registered flag set on any wrap.

Function
REQ-014 step SHALL equal carry_in when EDGE_MODE=0, and carry_in & ~carry_q when EDGE_MODE=1, where carry_q is carry_in registered one clk earlier.
REQ-015 Per-edge priority SHALL be: load > step > hold.
REQ-016 When load=1, count SHALL take min(load_val, limit) on the next edge, and a coincident step SHALL be discarded.
REQ-017 On an up step (ctrl=0) with count < limit, count SHALL become count+1.
REQ-018 On an up step with count >= limit, count SHALL become 0 (wrap), including when count > limit after limit was lowered.
REQ-019 On a down step (ctrl=1) with count > limit, count SHALL become limit without wrapping.
REQ-020 On a down step with 0 < count <= limit, count SHALL become count-1.
REQ-021 On a down step with count = 0, count SHALL become limit (wrap).
REQ-022 ripple_out SHALL be step & (ctrl ? count==0 : count>=limit), asserting in the same cycle as the wrap-causing step so the next stage steps on the same edge.
REQ-023 ripple_out SHALL NOT be asserted when load=1.
REQ-024 wrap_sticky SHALL set on any edge where a wrap occurs (REQ-018 or REQ-021).
REQ-025 wrap_sticky SHALL clear on an edge with clr_sticky=1 and no wrap; a coincident wrap wins and wrap_sticky stays 1.
REQ-026 limit=0 SHALL make every step a wrap: count stays 0 and ripple_out = step.
REQ-027 A ctrl change SHALL take effect on the very next step with no extra latency.
REQ-028 All arithmetic SHALL be unsigned WIDTH bits, and count SHALL never exceed 2^WIDTH-1.
REQ-029 Latency from a step or load to the new count SHALL be one clk edge.

Reset
REQ-030 clear_n=0 SHALL immediately force count=0, wrap_sticky=0 and carry_q=0, independent of clk.
REQ-031 ripple_out SHALL follow its combinational definition during reset.
REQ-032 After clear_n rises, the first step SHALL be taken on the first clk edge with step=1.
REQ-033 With EDGE_MODE=1, a carry_in that is already high at reset release SHALL count as a rising edge.
REQ-034 Reset asserted mid-operation SHALL abandon any pending load or step.

Verification
REQ-035 The bench SHALL cover up-count wrap: limit=20, ctrl=0, carry_in=1 for 21 edges from 0 -> count 1..20 then 0; ripple_out=1 only while count=20; wrap_sticky=1.
REQ-036 The bench SHALL cover down-count wrap: limit=20, count=0, ctrl=1, one carry_in pulse -> count=20, ripple_out=1 during the pulse, next pulse -> 19.
REQ-037 The bench SHALL cover edge mode: EDGE_MODE=1, carry_in held high 5 cycles -> count advances exactly 1.
REQ-038 The bench SHALL cover load vs. step: load=1, load_val=30, limit=20, carry_in=1 -> count=20, ripple_out=0, no wrap.
REQ-039 The bench SHALL cover a lowered limit: count=15, limit changed to 10, up step -> 0 with wrap_sticky=1; count=15, limit=10, down step -> 10.
REQ-040 The bench SHALL cover async reset: clear_n pulled low between clk edges with count=7 and wrap_sticky=1 -> count=0 and wrap_sticky=0 before the next edge; clr_sticky coincident with a wrap -> wrap_sticky remains 1.
